// File: rtl/divider_unit_pkg.sv
// Shared constants for the iterative divider: operation codes, FSM state codes
// and the common status macro.
`ifndef ASSERT_SUCCESS
`define ASSERT_SUCCESS 1'b1
`endif

package divider_unit_pkg;

    localparam logic [1:0] OP_DIV  = 2'd0;
    localparam logic [1:0] OP_DIVU = 2'd1;
    localparam logic [1:0] OP_REM  = 2'd2;
    localparam logic [1:0] OP_REMU = 2'd3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/divider_unit.sv
// Radix-2 restoring divider with a register-file writeback port; divide-by-zero
// and signed overflow bypass the iteration and complete in one cycle.
module divider_unit
    import divider_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [4:0]      rd,
    input  logic            kill,
    output logic            busy,
    output logic            done,
    output logic            wb_we,
    output logic [4:0]      wb_a3,
    output logic [XLEN-1:0] wb_di
);

    function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic neg);
        return neg ? ('0 - v) : v;
    endfunction

    logic [1:0]      state, state_nx;
    logic [5:0]      cnt;
    logic [1:0]      op_q;
    logic [4:0]      rd_q;
    logic            quo_neg_q, rem_neg_q;
    logic [XLEN-1:0] dvsr_q, quo_q, rem_q, result_q;

    logic signed [XLEN-1:0] a_s, b_s;
    logic            is_signed, a_neg, b_neg, div_zero, ovf, special, accept, fire;
    logic [XLEN-1:0] special_res, quo_fix, rem_fix;
    logic [XLEN:0]   r_shift, diff;

    assign a_s = a;
    assign b_s = b;

    always_comb begin
        is_signed   = ~op[0];
        a_neg       = is_signed & (a_s < 0);
        b_neg       = is_signed & (b_s < 0);
        div_zero    = (b == '0);
        ovf         = is_signed & (a == {1'b1, {(XLEN-1){1'b0}}}) & (b == '1);
        special     = div_zero | ovf;
        accept      = (state == ST_IDLE) & start & ~kill;
        if (div_zero)
            special_res = op[1] ? a : '1;
        else
            special_res = op[1] ? '0 : a;
        r_shift     = {rem_q, quo_q[XLEN-1]};
        diff        = r_shift - {1'b0, dvsr_q};
        quo_fix     = neg_if(quo_q, quo_neg_q);
        rem_fix     = neg_if(rem_q, rem_neg_q);
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (accept) state_nx = special ? ST_DONE : ST_CALC;
            ST_CALC: begin
                if (kill)
                    state_nx = ST_IDLE;
                else if (cnt == 6'd32)
                    state_nx = ST_DONE;
            end
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    // Counts 0..31 for the shift-subtract steps; the extra count 32 applies the sign fix-up.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt       <= '0;
            op_q      <= '0;
            rd_q      <= '0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            dvsr_q    <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            result_q  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_q      <= op;
                        rd_q      <= rd;
                        quo_neg_q <= a_neg ^ b_neg;
                        rem_neg_q <= a_neg;
                        dvsr_q    <= neg_if(b, b_neg);
                        quo_q     <= neg_if(a, a_neg);
                        rem_q     <= '0;
                        cnt       <= '0;
                        result_q  <= special_res;
                    end
                end
                ST_CALC: begin
                    if (!kill) begin
                        if (cnt != 6'd32) begin
                            rem_q <= diff[XLEN] ? r_shift[XLEN-1:0] : diff[XLEN-1:0];
                            quo_q <= {quo_q[XLEN-2:0], ~diff[XLEN]};
                            cnt   <= cnt + 6'd1;
                        end else begin
                            result_q <= op_q[1] ? rem_fix : quo_fix;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // A kill landing on the DONE cycle suppresses the pulse and the write.
    always_comb begin
        fire  = (state == ST_DONE) & ~kill;
        busy  = (state != ST_IDLE);
        done  = fire;
        wb_we = fire & (rd_q != 5'd0);
        wb_a3 = fire ? rd_q : 5'd0;
        wb_di = fire ? result_q : '0;
    end

endmodule

// File: tb/tb_divider_unit.sv
// Bench for divider_unit: vector table and random vectors checked through a
// result queue, plus directed sequences for kill, reset and start handling.
module tb_divider_unit;

    localparam logic [1:0] DIV = 2'd0, DIVU = 2'd1, REM = 2'd2, REMU = 2'd3;

    logic        clk, reset, start, kill;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic [4:0]  rd;
    logic        busy, done, wb_we;
    logic [4:0]  wb_a3;
    logic [31:0] wb_di;

    divider_unit #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b), .rd(rd),
        .kill(kill), .busy(busy), .done(done), .wb_we(wb_we), .wb_a3(wb_a3), .wb_di(wb_di)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] res;
        int          lat;
    } vec_t;

    typedef struct {
        logic        we;
        logic [4:0]  a3;
        logic [31:0] di;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[15];
    int total = 0;
    int bad = 0;
    int acc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h, want %h", name, act, req);
        end
    endtask

    function automatic logic [31:0] ref_res(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        if (y == 32'd0) return o[1] ? x : 32'hFFFF_FFFF;
        if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return o[1] ? 32'd0 : x;
        case (o)
            DIV:     return 32'($signed(x) / $signed(y));
            DIVU:    return x / y;
            REM:     return 32'($signed(x) % $signed(y));
            default: return x % y;
        endcase
    endfunction

    function automatic int ref_lat(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        if (y == 32'd0) return 0;
        if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 0;
        return 33;
    endfunction

    task automatic start_op(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv, input logic [4:0] r);
        @(negedge clk);
        start = 1'b1; op = o; a = av; b = bv; rd = r;
        @(posedge clk);
        #1;
        acc = cyc;
        start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom; rd = 5'($urandom);
    endtask

    task automatic expect_res(input logic [31:0] di, input logic [4:0] r, input int lat);
        exp_t e;
        e.we = (r != 5'd0); e.a3 = r; e.di = di; e.lat = lat; e.acc = acc;
        sb.push_back(e);
    endtask

    task automatic wait_result(input string name);
        exp_t e;
        bit seen;
        seen = 1'b0;
        if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL %s: no expectation queued", name);
            return;
        end
        e = sb.pop_front();
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                check({name, " lat"}, 32'(cyc - e.acc), 32'(e.lat));
                check({name, " we"}, 32'(wb_we), 32'(e.we));
                check({name, " a3"}, 32'(wb_a3), 32'(e.a3));
                check({name, " di"}, wb_di, e.di);
            end
        end
        if (!seen) begin
            total++; bad++;
            $display("FAIL %s timeout: done never rose, want lat %0d", name, e.lat);
        end
        @(negedge clk);
        check({name, " pulse"}, 32'(done), 32'd0);
    endtask

    task automatic no_done(input string name, input int n);
        int seen_n = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (done || wb_we) seen_n++;
        end
        check(name, 32'(seen_n), 32'd0);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; kill = 1'b0; op = 2'd0; a = '0; b = '0; rd = '0;

        vecs[0]  = '{DIVU, 32'd100,         32'd7,           5'd5,  32'd14,          33};
        vecs[1]  = '{REMU, 32'd100,         32'd7,           5'd6,  32'd2,           33};
        vecs[2]  = '{DIV,  32'hFFFF_FFF9,   32'd2,           5'd7,  32'hFFFF_FFFD,   33};
        vecs[3]  = '{REM,  32'hFFFF_FFF9,   32'd2,           5'd8,  32'hFFFF_FFFF,   33};
        vecs[4]  = '{DIVU, 32'd5,           32'd0,           5'd9,  32'hFFFF_FFFF,   0};
        vecs[5]  = '{REMU, 32'd5,           32'd0,           5'd10, 32'd5,           0};
        vecs[6]  = '{DIV,  32'h8000_0000,   32'hFFFF_FFFF,   5'd11, 32'h8000_0000,   0};
        vecs[7]  = '{REM,  32'h8000_0000,   32'hFFFF_FFFF,   5'd12, 32'd0,           0};
        vecs[8]  = '{DIVU, 32'hFFFF_FFFF,   32'd1,           5'd13, 32'hFFFF_FFFF,   33};
        vecs[9]  = '{DIV,  32'd7,           32'hFFFF_FFFE,   5'd14, 32'hFFFF_FFFD,   33};
        vecs[10] = '{REM,  32'd7,           32'hFFFF_FFFE,   5'd15, 32'd1,           33};
        vecs[11] = '{DIV,  32'h8000_0000,   32'd0,           5'd16, 32'hFFFF_FFFF,   0};
        vecs[12] = '{DIVU, 32'd100,         32'd7,           5'd0,  32'd14,          33};
        vecs[13] = '{DIV,  32'h8000_0000,   32'd1,           5'd17, 32'h8000_0000,   33};
        vecs[14] = '{REMU, 32'hFFFF_FFFF,   32'h10,          5'd31, 32'hF,           33};

        #12;
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst we", 32'(wb_we), 32'd0);
        check("rst a3", 32'(wb_a3), 32'd0);
        check("rst di", wb_di, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 15; i++) begin
            start_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd);
            expect_res(vecs[i].res, vecs[i].rd, vecs[i].lat);
            wait_result($sformatf("vec%0d", i));
        end

        for (int i = 0; i < 6; i++) begin
            logic [1:0]  o;
            logic [31:0] x, y;
            o = 2'($urandom);
            x = $urandom;
            y = $urandom >> $urandom_range(0, 31);
            start_op(o, x, y, 5'd20);
            expect_res(ref_res(o, x, y), 5'd20, ref_lat(o, x, y));
            wait_result($sformatf("rnd%0d", i));
        end

        // second start during CALC must be ignored
        start_op(DIVU, 32'd1000, 32'd10, 5'd3);
        expect_res(32'd100, 5'd3, 33);
        repeat (3) @(negedge clk);
        check("calc busy", 32'(busy), 32'd1);
        check("calc di", wb_di, 32'd0);
        start = 1'b1; op = DIVU; a = 32'd50; b = 32'd5; rd = 5'd4;
        @(negedge clk);
        start = 1'b0;
        wait_result("ignore");
        no_done("ignore once", 45);

        // start held across DONE is taken in the following IDLE cycle
        start_op(DIVU, 32'd5, 32'd0, 5'd9);
        expect_res(32'hFFFF_FFFF, 5'd9, 0);
        start = 1'b1; op = DIVU; a = 32'd100; b = 32'd7; rd = 5'd21;
        @(posedge clk); #1;
        check("b2b idle", 32'(busy), 32'd0);
        @(posedge clk); #1;
        check("b2b accept", 32'(busy), 32'd1);
        start = 1'b0;
        begin
            exp_t e;
            e = sb.pop_front();
            check("b2b first di", e.di, 32'hFFFF_FFFF);
        end
        acc = cyc;
        expect_res(32'd14, 5'd21, 33);
        wait_result("b2b");

        // kill in CALC
        start_op(DIVU, 32'd100, 32'd7, 5'd5);
        repeat (5) @(negedge clk);
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        check("kill calc busy", 32'(busy), 32'd0);
        no_done("kill calc", 40);

        // kill on the DONE cycle
        start_op(DIVU, 32'd5, 32'd0, 5'd9);
        kill = 1'b1;
        #1;
        check("kill done pulse", 32'(done), 32'd0);
        check("kill done we", 32'(wb_we), 32'd0);
        @(posedge clk); #1;
        kill = 1'b0;
        check("kill done busy", 32'(busy), 32'd0);
        no_done("kill done", 10);

        // kill beats start in IDLE
        @(negedge clk);
        start = 1'b1; kill = 1'b1; op = DIVU; a = 32'd9; b = 32'd3; rd = 5'd1;
        @(posedge clk); #1;
        start = 1'b0; kill = 1'b0;
        check("kill start busy", 32'(busy), 32'd0);
        no_done("kill start", 40);

        // asynchronous reset at CALC cycle 10
        start_op(DIVU, 32'd100, 32'd7, 5'd5);
        repeat (10) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("arst busy", 32'(busy), 32'd0);
        check("arst di", wb_di, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        no_done("arst no done", 40);

        // start coincident with reset release is taken on the first edge
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1; start = 1'b1; op = REMU; a = 32'd77; b = 32'd0; rd = 5'd2;
        @(posedge clk); #1;
        acc = cyc;
        start = 1'b0;
        expect_res(32'd77, 5'd2, 0);
        wait_result("rel first");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
